// File: rtl/rlwe_vdmem_pkg.sv
// Shared types for the RLWE vector data memory responder.
// Memory interface enums, vector type and FSM states.
package rlwe_vdmem_pkg;

  localparam int AWIDTH = 32;
  localparam int LANE   = 4;

  localparam logic [AWIDTH-1:0] BASE_ADDR_DFLT = 32'h0048_0000;

  typedef enum logic {
    MEM_CMD_RD = 1'b0,
    MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [2:0] {
    MEM_WIDTH_BYTE   = 3'd0,
    MEM_WIDTH_HWORD  = 3'd1,
    MEM_WIDTH_WORD   = 3'd2,
    MEM_WIDTH_VECTOR = 3'd3
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    MEM_RESP_NOTRDY = 2'd0,
    MEM_RESP_RDY_OK = 2'd1,
    MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

  typedef logic [LANE-1:0][31:0] type_vector;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Width codes outside the defined set behave as a word access.
  function automatic type_scr1_mem_width_e norm_width(
    input type_scr1_mem_width_e w
  );
    case (w)
      MEM_WIDTH_BYTE,
      MEM_WIDTH_HWORD,
      MEM_WIDTH_WORD,
      MEM_WIDTH_VECTOR: return w;
      default:          return MEM_WIDTH_WORD;
    endcase
  endfunction

endpackage

// File: rtl/rlwe_vdmem_resp_if.sv
// LSU <-> vector data memory request/response bus.
// master = LSU side, slave = memory side.
interface rlwe_vdmem_resp_if;
  import rlwe_vdmem_pkg::*;

  logic                 lsu2dmem_req;
  type_scr1_mem_cmd_e   lsu2dmem_cmd;
  type_scr1_mem_width_e lsu2dmem_width;
  logic [AWIDTH-1:0]    lsu2dmem_addr;
  type_vector           lsu2dmem_wdata;
  logic                 dmem2lsu_req_ack;
  type_vector           dmem2lsu_rdata;
  type_scr1_mem_resp_e  dmem2lsu_resp;

  modport master (
    output lsu2dmem_req,
    output lsu2dmem_cmd,
    output lsu2dmem_width,
    output lsu2dmem_addr,
    output lsu2dmem_wdata,
    input  dmem2lsu_req_ack,
    input  dmem2lsu_rdata,
    input  dmem2lsu_resp
  );

  modport slave (
    input  lsu2dmem_req,
    input  lsu2dmem_cmd,
    input  lsu2dmem_width,
    input  lsu2dmem_addr,
    input  lsu2dmem_wdata,
    output dmem2lsu_req_ack,
    output dmem2lsu_rdata,
    output dmem2lsu_resp
  );

endinterface

// File: rtl/rlwe_vdmem_bank.sv
// One lane of vector memory: 32-bit x DEPTH, byte enables.
// Read data is registered and held until the next read.
module rlwe_vdmem_bank #(
  parameter int DEPTH = 256,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  output logic [31:0]   o_rdata
);

  logic [3:0][7:0] r_mem [DEPTH];
  logic [31:0]     r_rdata;

  // Byte-masked write and registered read; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][b] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rlwe_vdmem_resp.sv
// Vector data memory responder: one outstanding request,
// fixed read latency, address/alignment error reporting.
module rlwe_vdmem_resp
  import rlwe_vdmem_pkg::*;
#(
  parameter int                DEPTH      = 256,
  parameter int                RD_LATENCY = 1,
  parameter logic [AWIDTH-1:0] BASE_ADDR  = BASE_ADDR_DFLT
) (
  input logic               clk,
  input logic               rst,
  rlwe_vdmem_resp_if.slave  bus
);

  localparam int LWB     = $clog2(LANE);
  localparam int ROW_LSB = LWB + 2;
  localparam int RW      = $clog2(DEPTH);
  localparam int OW      = ROW_LSB + RW;

  localparam logic [AWIDTH:0] SPAN =
    (AWIDTH+1)'(DEPTH * LANE * 4);
  localparam logic [AWIDTH:0] LIMIT =
    {1'b0, BASE_ADDR} + SPAN;

  localparam bit ONE_CYC = (RD_LATENCY <= 1);
  localparam logic [1:0] CNT_INIT =
    ONE_CYC ? 2'd0 : 2'(RD_LATENCY - 2);

  state_e               r_state;
  logic [1:0]           r_cnt;
  type_scr1_mem_resp_e  r_resp;
  type_scr1_mem_cmd_e   r_cmd;
  type_scr1_mem_width_e r_width;
  logic [LWB-1:0]       r_lane;
  logic [1:0]           r_byte;
  logic                 r_err;

  type_scr1_mem_width_e w_width;
  logic [OW-1:0]        w_off;
  logic [RW-1:0]        w_row;
  logic [LWB-1:0]       w_lane;
  logic [1:0]           w_byte;
  logic                 w_lo;
  logic                 w_hi;
  logic                 w_mis;
  logic                 w_err;
  logic                 w_acc;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_vec;
  logic [31:0]          w_wword;
  logic [3:0]           w_be;
  type_vector           w_bank;
  logic [31:0]          w_word;
  logic [31:0]          w_sh;
  type_vector           w_rdata;

  assign w_width = norm_width(bus.lsu2dmem_width);
  assign w_vec   = (w_width == MEM_WIDTH_VECTOR);

  assign w_off  = bus.lsu2dmem_addr[OW-1:0]
                - BASE_ADDR[OW-1:0];
  assign w_row  = w_off[ROW_LSB +: RW];
  assign w_lane = w_off[ROW_LSB-1:2];
  assign w_byte = w_off[1:0];

  assign w_lo = bus.lsu2dmem_addr < BASE_ADDR;
  assign w_hi = {1'b0, bus.lsu2dmem_addr} >= LIMIT;

  // Alignment check against the access size.
  always_comb begin
    w_mis = 1'b0;
    case (w_width)
      MEM_WIDTH_HWORD:  w_mis = bus.lsu2dmem_addr[0];
      MEM_WIDTH_WORD:   w_mis = |bus.lsu2dmem_addr[1:0];
      MEM_WIDTH_VECTOR: w_mis = |bus.lsu2dmem_addr[ROW_LSB-1:0];
      default:          w_mis = 1'b0;
    endcase
  end

  assign w_err = w_lo | w_hi | w_mis;
  assign w_acc = bus.lsu2dmem_req & (r_state == ST_IDLE);
  assign w_wr  = w_acc & ~w_err
               & (bus.lsu2dmem_cmd == MEM_CMD_WR);
  assign w_rd  = w_acc & ~w_err
               & (bus.lsu2dmem_cmd == MEM_CMD_RD);

  // Replicate sub-word store data and pick the byte lanes.
  always_comb begin
    w_wword = bus.lsu2dmem_wdata[0];
    w_be    = 4'b1111;
    case (w_width)
      MEM_WIDTH_BYTE: begin
        w_wword = {4{bus.lsu2dmem_wdata[0][7:0]}};
        w_be    = 4'b0001 << w_byte;
      end
      MEM_WIDTH_HWORD: begin
        w_wword = {2{bus.lsu2dmem_wdata[0][15:0]}};
        w_be    = w_byte[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wword = bus.lsu2dmem_wdata[0];
        w_be    = 4'b1111;
      end
    endcase
  end

  for (genvar l = 0; l < LANE; l++) begin : g_lane
    rlwe_vdmem_bank #(.DEPTH(DEPTH)) u_bank (
      .clk     (clk),
      .i_we    (w_wr),
      .i_be    ((w_vec || (w_lane == LWB'(l))) ? w_be : 4'b0000),
      .i_addr  (w_row),
      .i_wdata (w_vec ? bus.lsu2dmem_wdata[l] : w_wword),
      .i_re    (w_rd),
      .o_rdata (w_bank[l])
    );
  end

  // Request FSM: latch on accept, count latency, one-cycle response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_resp  <= MEM_RESP_NOTRDY;
      r_cmd   <= MEM_CMD_RD;
      r_width <= MEM_WIDTH_BYTE;
      r_lane  <= '0;
      r_byte  <= 2'd0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.lsu2dmem_req) begin
            r_cmd   <= bus.lsu2dmem_cmd;
            r_width <= w_width;
            r_lane  <= w_lane;
            r_byte  <= w_byte;
            r_err   <= w_err;
            r_cnt   <= CNT_INIT;
            if (ONE_CYC) begin
              r_state <= ST_RESP;
              r_resp  <= w_err ? MEM_RESP_RDY_ER
                               : MEM_RESP_RDY_OK;
            end else begin
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state <= ST_RESP;
            r_resp  <= r_err ? MEM_RESP_RDY_ER
                             : MEM_RESP_RDY_OK;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_resp  <= MEM_RESP_NOTRDY;
        end
        default: begin
          r_state <= ST_IDLE;
          r_resp  <= MEM_RESP_NOTRDY;
        end
      endcase
    end
  end

  assign w_word = w_bank[r_lane];
  assign w_sh   = w_word >> {r_byte, 3'b000};

  // Format load data; zero everywhere but a good read response.
  always_comb begin
    w_rdata = '0;
    if (r_resp == MEM_RESP_RDY_OK && r_cmd == MEM_CMD_RD) begin
      case (r_width)
        MEM_WIDTH_VECTOR: w_rdata    = w_bank;
        MEM_WIDTH_BYTE:   w_rdata[0] = {24'd0, w_sh[7:0]};
        MEM_WIDTH_HWORD:  w_rdata[0] = {16'd0, w_sh[15:0]};
        default:          w_rdata[0] = w_word;
      endcase
    end
  end

  assign bus.dmem2lsu_req_ack = (r_state == ST_IDLE);
  assign bus.dmem2lsu_resp    = r_resp;
  assign bus.dmem2lsu_rdata   = w_rdata;

endmodule

// File: tb/tb_rlwe_vdmem_resp.sv
// Directed bench for rlwe_vdmem_resp at read latency 1 and 3.
// Expected values are hand-computed constants.
module tb_rlwe_vdmem_resp;
  import rlwe_vdmem_pkg::*;

  logic clk = 1'b0;
  logic rst1;
  logic rst3;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rlwe_vdmem_resp_if b1();
  rlwe_vdmem_resp_if b3();

  rlwe_vdmem_resp #(
    .DEPTH(256), .RD_LATENCY(1), .BASE_ADDR(32'h0048_0000)
  ) u_dut1 (
    .clk(clk), .rst(rst1), .bus(b1.slave)
  );

  rlwe_vdmem_resp #(
    .DEPTH(256), .RD_LATENCY(3), .BASE_ADDR(32'h0048_0000)
  ) u_dut3 (
    .clk(clk), .rst(rst3), .bus(b3.slave)
  );

  localparam type_scr1_mem_cmd_e RD = MEM_CMD_RD;
  localparam type_scr1_mem_cmd_e WR = MEM_CMD_WR;
  localparam type_scr1_mem_width_e WB = MEM_WIDTH_BYTE;
  localparam type_scr1_mem_width_e WH = MEM_WIDTH_HWORD;
  localparam type_scr1_mem_width_e WW = MEM_WIDTH_WORD;
  localparam type_scr1_mem_width_e WV = MEM_WIDTH_VECTOR;
  localparam type_scr1_mem_resp_e NR = MEM_RESP_NOTRDY;
  localparam type_scr1_mem_resp_e OK = MEM_RESP_RDY_OK;
  localparam type_scr1_mem_resp_e ER = MEM_RESP_RDY_ER;

  function automatic type_vector w0(input logic [31:0] x);
    return {96'd0, x};
  endfunction

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency-1 transaction: checks ack, response, latency, load data.
  task automatic op1(input string tag,
                     input type_scr1_mem_cmd_e c,
                     input type_scr1_mem_width_e w,
                     input logic [31:0] a,
                     input type_vector d,
                     input type_scr1_mem_resp_e ers,
                     input type_vector erd);
    logic ack;
    int   lat;
    @(negedge clk);
    b1.lsu2dmem_req   = 1'b1;
    b1.lsu2dmem_cmd   = c;
    b1.lsu2dmem_width = w;
    b1.lsu2dmem_addr  = a;
    b1.lsu2dmem_wdata = d;
    ack = b1.dmem2lsu_req_ack;
    @(negedge clk);
    b1.lsu2dmem_req = 1'b0;
    lat = 1;
    while (b1.dmem2lsu_resp == NR && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".ack"}, 128'(ack), 128'(1'b1));
    chk({tag, ".resp"}, 128'(b1.dmem2lsu_resp), 128'(ers));
    chk({tag, ".lat"}, 128'(lat), 128'(1));
    if (c == RD)
      chk({tag, ".rdata"}, 128'(b1.dmem2lsu_rdata), 128'(erd));
  endtask

  // Latency-3 transaction with cycle-by-cycle protocol checks.
  task automatic op3(input string tag,
                     input type_scr1_mem_cmd_e c,
                     input type_scr1_mem_width_e w,
                     input logic [31:0] a,
                     input type_vector d,
                     input type_scr1_mem_resp_e ers,
                     input type_vector erd);
    @(negedge clk);
    b3.lsu2dmem_req   = 1'b1;
    b3.lsu2dmem_cmd   = c;
    b3.lsu2dmem_width = w;
    b3.lsu2dmem_addr  = a;
    b3.lsu2dmem_wdata = d;
    chk({tag, ".c0.ack"}, 128'(b3.dmem2lsu_req_ack), 128'(1'b1));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      b3.lsu2dmem_req = 1'b0;
      chk($sformatf("%s.c%0d.ack", tag, k),
          128'(b3.dmem2lsu_req_ack), 128'(k == 4));
      chk($sformatf("%s.c%0d.resp", tag, k),
          128'(b3.dmem2lsu_resp), 128'((k == 3) ? ers : NR));
      if (c == RD || k != 3)
        chk($sformatf("%s.c%0d.rdata", tag, k),
            128'(b3.dmem2lsu_rdata),
            (k == 3) ? 128'(erd) : 128'(0));
    end
  endtask

  // Start a latency-3 request and pulse reset in its WAIT cycle.
  task automatic abort3(input string tag,
                        input type_scr1_mem_cmd_e c,
                        input logic [31:0] a,
                        input type_vector d);
    int seen;
    @(negedge clk);
    b3.lsu2dmem_req   = 1'b1;
    b3.lsu2dmem_cmd   = c;
    b3.lsu2dmem_width = WW;
    b3.lsu2dmem_addr  = a;
    b3.lsu2dmem_wdata = d;
    @(negedge clk);
    b3.lsu2dmem_req = 1'b0;
    seen = (b3.dmem2lsu_resp != NR) ? 1 : 0;
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    chk({tag, ".ack"}, 128'(b3.dmem2lsu_req_ack), 128'(1'b1));
    for (int k = 0; k < 5; k++) begin
      if (b3.dmem2lsu_resp != NR) seen++;
      @(negedge clk);
    end
    chk({tag, ".noresp"}, 128'(seen), 128'(0));
  endtask

  type_vector v1234;
  type_vector vlv0;

  initial begin
    v1234 = {32'd4, 32'd3, 32'd2, 32'd1};
    vlv0  = {32'd0, 32'd0, 32'h0000_AB00, 32'hBEEF_0000};
    rst1 = 1'b1;
    rst3 = 1'b1;
    b1.lsu2dmem_req   = 1'b0;
    b1.lsu2dmem_cmd   = RD;
    b1.lsu2dmem_width = WW;
    b1.lsu2dmem_addr  = '0;
    b1.lsu2dmem_wdata = '0;
    b3.lsu2dmem_req   = 1'b0;
    b3.lsu2dmem_cmd   = RD;
    b3.lsu2dmem_width = WW;
    b3.lsu2dmem_addr  = '0;
    b3.lsu2dmem_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst.ack", 128'(b1.dmem2lsu_req_ack), 128'(1'b1));
    chk("rst.resp", 128'(b1.dmem2lsu_resp), 128'(NR));
    chk("rst.rdata", 128'(b1.dmem2lsu_rdata), 128'(0));
    chk("rst3.ack", 128'(b3.dmem2lsu_req_ack), 128'(1'b1));
    rst1 = 1'b0;
    rst3 = 1'b0;

    op1("sv", WR, WV, 32'h0048_0010, v1234, OK, '0);
    op1("lv", RD, WV, 32'h0048_0010, '0, OK, v1234);
    @(negedge clk);
    chk("lv.after.resp", 128'(b1.dmem2lsu_resp), 128'(NR));
    chk("lv.after.rdata", 128'(b1.dmem2lsu_rdata), 128'(0));
    chk("lv.after.ack", 128'(b1.dmem2lsu_req_ack), 128'(1'b1));

    op1("sv0", WR, WV, 32'h0048_0000, '0, OK, '0);
    op1("sb", WR, WB, 32'h0048_0005, w0(32'hAB), OK, '0);
    op1("lw", RD, WW, 32'h0048_0004, '0, OK, w0(32'h0000_AB00));
    op1("lb", RD, WB, 32'h0048_0005, '0, OK, w0(32'h0000_00AB));
    op1("lh", RD, WH, 32'h0048_0004, '0, OK, w0(32'h0000_AB00));
    op1("lhh", RD, WH, 32'h0048_0006, '0, OK, w0(32'h0));
    op1("sh", WR, WH, 32'h0048_0002, w0(32'hFFFF_BEEF), OK, '0);
    op1("lv0", RD, WV, 32'h0048_0000, '0, OK, vlv0);

    op1("lw_lo", RD, WW, 32'h0047_FFFC, '0, ER, '0);
    op1("lv_mis", RD, WV, 32'h0048_0008, '0, ER, '0);
    op1("sw_mis", WR, WW, 32'h0048_0012, w0(32'hDEAD_BEEF), ER, '0);
    op1("sh_mis", WR, WH, 32'h0048_0011, w0(32'h0000_5555), ER, '0);
    op1("sv_lo", WR, WV, 32'h0047_FFF0, '1, ER, '0);
    op1("lv_keep", RD, WV, 32'h0048_0010, '0, OK, v1234);
    op1("lv0_keep", RD, WV, 32'h0048_0000, '0, OK, vlv0);

    op1("sw_last", WR, WW, 32'h0048_0FFC, w0(32'h1234_5678), OK, '0);
    op1("lw_last", RD, WW, 32'h0048_0FFC, '0, OK, w0(32'h1234_5678));
    op1("lw_end", RD, WW, 32'h0048_1000, '0, ER, '0);
    op1("lb_last", RD, WB, 32'h0048_0FFF, '0, OK, w0(32'h12));
    op1("lh_last", RD, WH, 32'h0048_0FFE, '0, OK, w0(32'h1234));
    op1("lx_unk", RD, type_scr1_mem_width_e'(3'd5),
        32'h0048_0FFC, '0, OK, w0(32'h1234_5678));
    op1("lx_mis", RD, type_scr1_mem_width_e'(3'd6),
        32'h0048_0FFE, '0, ER, '0);

    op3("l3_sw", WR, WW, 32'h0048_0020, w0(32'hCAFE_F00D), OK, '0);
    op3("l3_lw", RD, WW, 32'h0048_0020, '0, OK, w0(32'hCAFE_F00D));
    op3("l3_er", RD, WW, 32'h0048_0021, '0, ER, '0);

    abort3("ab_lw", RD, 32'h0048_0020, '0);
    abort3("ab_sw", WR, 32'h0048_0024, w0(32'h5A5A_5A5A));
    op3("l3_keep", RD, WW, 32'h0048_0024, '0, OK, w0(32'h5A5A_5A5A));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rlwe_vdmem_resp.md
RLWE_VDMEM_RESP -- requirements
Module: rlwe_vdmem_resp

Interface
REQ-001 Parameter DEPTH, 256, number of vector rows; each row holds `LANE 32-bit words; power of two.
REQ-002 Parameter RD_LATENCY, 1, cycles from request acceptance to response; legal range 1..4.
REQ-003 Parameter BASE_ADDR, `SCR1_DMEM_AWIDTH'h480000, first byte address served.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 lsu2dmem_req  input  1  request valid.
REQ-007 lsu2dmem_cmd  input  type_scr1_mem_cmd_e  RD or WR.
REQ-008 lsu2dmem_width  input  type_scr1_mem_width_e  BYTE, HWORD, WORD or VECTOR.
REQ-009 lsu2dmem_addr  input  `SCR1_DMEM_AWIDTH  byte address.
REQ-010 lsu2dmem_wdata  input  type_vector  store data; sub-word stores take data right-aligned in lane 0.
REQ-011 dmem2lsu_req_ack  output  1  request accepted this cycle when high together with req.
REQ-012 dmem2lsu_rdata  output  type_vector  load data, valid only in the RDY_OK cycle.
REQ-013 dmem2lsu_resp  output  type_scr1_mem_resp_e  NOTRDY, RDY_OK or RDY_ER.

Function
REQ-014 FSM states IDLE, WAIT and RESP; one outstanding request only.
REQ-015 dmem2lsu_req_ack SHALL be 1 in IDLE only, combinationally from state.
REQ-016 IDLE with req=1 -> latch cmd, width, addr, error flag; go WAIT if RD_LATENCY>1, else RESP; load latency counter with RD_LATENCY-2.
REQ-017 WAIT decrements the counter; at 0 -> RESP.
REQ-018 RESP drives resp RDY_OK or RDY_ER for exactly one cycle, then -> IDLE; resp is NOTRDY in every other cycle.
REQ-019 Acceptance at edge N -> response visible in cycle N+RD_LATENCY; the next request can be accepted at the earliest in cycle N+RD_LATENCY+1.
REQ-020 Error condition: addr < BASE_ADDR, or addr >= BASE_ADDR+DEPTH*`LANE*4, or misalignment (HWORD: addr[0]; WORD: addr[1:0]; VECTOR: addr[$clog2(`LANE)+1:0] nonzero).
REQ-021 An errored request SHALL not modify memory and SHALL return RDY_ER with rdata all zero.
REQ-022 Decode from offset = addr-BASE_ADDR: row = offset[$clog2(`LANE)+2 +: $clog2(DEPTH)]; lane = offset[$clog2(`LANE)+1:2]; byte = offset[1:0].
REQ-023 A write commits at the acceptance edge; byte enables cover only the addressed bytes; VECTOR writes all lanes of the row.
REQ-024 A read samples the row at the acceptance edge and holds it until RESP; a read accepted after a write returns the written data.
REQ-025 Sub-word reads return the addressed byte/halfword/word zero-extended into rdata[0]; lanes 1..`LANE-1 SHALL be zero; VECTOR returns the full row.
REQ-026 rdata SHALL be zero outside the RDY_OK cycle.
REQ-027 req with an unknown width value SHALL be treated as WORD.

Reset
REQ-028 rst=1 -> state IDLE, counter 0, resp NOTRDY, rdata zero, latched request cleared; memory contents are not reset.
REQ-029 rst asserted during WAIT or RESP aborts the transaction with no response; a write accepted before the reset stays committed.

Structure
REQ-030 Package rlwe_vdmem_pkg holds the FSM state enum and the BASE_ADDR default; the mem and vector types are already defined in scr1_memif.svh and defines.svh.
REQ-031 Sub-module rlwe_vdmem_bank is one 32-bit x DEPTH RAM with 4 byte enables and a registered read, instantiated `LANE times.

Verification
REQ-032 With LATENCY=1 and LANE=4: SV 0x480010 data {1,2,3,4}, then LV 0x480010 -> RDY_OK one cycle after accept; rdata {1,2,3,4}.
REQ-033 SB 0x480005 data 0xAB over a zeroed row, then LW 0x480004 -> rdata[0]=0x0000AB00; other lanes 0.
REQ-034 LW 0x47FFFC (below base), then LV 0x480008 (misaligned) -> RDY_ER each time, rdata 0, memory unchanged.
REQ-035 RD_LATENCY=3: accept at cycle 10 -> resp at cycle 13, req_ack low in cycles 11-13 and high in cycle 14.
REQ-036 rst pulsed in the WAIT cycle of an LW -> no RDY_OK/ER seen; IDLE with req_ack=1 on the cycle after reset.
REQ-037 LW of the last word (BASE+DEPTH*16-4) -> RDY_OK; LW of BASE+DEPTH*16 -> RDY_ER.
